// File: rtl/main_memory_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : main_memory_responder_pkg
// Description : Shared memory-side types and constants for the L1 data cache
//               refill/writeback interface (block geometry, block type and
//               the responder FSM state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package main_memory_responder_pkg;

  // Cache block geometry shared by the cache controller and memory side.
  localparam int CACHE_BLOCK_SIZE = 128;
  localparam int MEM_NUM_BLOCKS   = 4096;

  // Byte-offset bits inside a block and block-index bits of the backing store.
  localparam int OFFSET_BITS    = $clog2(CACHE_BLOCK_SIZE / 8);
  localparam int MEM_INDEX_BITS = $clog2(MEM_NUM_BLOCKS);

  typedef logic [CACHE_BLOCK_SIZE-1:0] mem_block_t;

  // Responder sequencing: idle, counting down the read latency, responding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_resp_state_t;

  // Clear the byte-offset bits of an address so it names a whole block.
  function automatic logic [31:0] block_align(input logic [31:0] addr,
                                              input int          offset_bits);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << offset_bits;
    return addr & mask;
  endfunction

endpackage : main_memory_responder_pkg
`default_nettype wire

// File: rtl/main_memory_responder_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with wrap-bit pointers, head peek,
//               occupancy count and synchronous active-high reset.
//               DEPTH must be a power of two, at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Equal pointers mean empty; same slot with differing wrap bits means full.
  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign full_o  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign count_o = r_wr_ptr - r_rd_ptr;
  assign rdata_o = r_mem[r_rd_ptr[c_AW-1:0]];

  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  // Pointer update; the wrap bit rolls over naturally at 2*DEPTH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= wdata_i;
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/main_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : main_memory_responder
// Description : Memory-side endpoint of the L1 D-cache refill/writeback
//               interface. Queues block refill requests, answers each one
//               with a full block after a fixed read latency, and absorbs
//               evicted-block writebacks into a block-organised store.
// Revision    : 1.0 - initial release
// ============================================================================
module main_memory_responder
  import main_memory_responder_pkg::*;
#(
  parameter int BLOCK_BITS     = CACHE_BLOCK_SIZE,
  parameter int NUM_BLOCKS     = MEM_NUM_BLOCKS,
  parameter int RD_LATENCY     = 8,
  parameter int REQ_FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_req_vld_i,
  input  logic [31:0]           mem_req_addr_i,
  output logic                  mem_req_rdy_o,
  output logic                  mem_resp_vld_o,
  output logic [BLOCK_BITS-1:0] mem_resp_data_o,
  output logic [31:0]           mem_resp_addr_o,
  input  logic                  mem_wb_vld_i,
  input  logic [31:0]           mem_wb_addr_i,
  input  logic [BLOCK_BITS-1:0] mem_wb_data_i,
  output logic                  busy_o
);

  localparam int c_OFFSET_BITS = $clog2(BLOCK_BITS / 8);
  localparam int c_INDEX_BITS  = $clog2(NUM_BLOCKS);
  localparam int c_FIFO_CW     = $clog2(REQ_FIFO_DEPTH) + 1;
  localparam int c_CNT_W       = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;

  // Cycle budget: accept edge -> IDLE cycle -> WAIT cycles -> RESP cycle.
  // From IDLE there are RD_LATENCY-2 WAIT cycles; from RESP (back-to-back)
  // there are RD_LATENCY-1, because no IDLE cycle sits in between.
  localparam logic [c_CNT_W-1:0] c_LOAD_FROM_IDLE =
    c_CNT_W'((RD_LATENCY >= 3) ? (RD_LATENCY - 3) : 0);
  localparam logic [c_CNT_W-1:0] c_LOAD_FROM_RESP = c_CNT_W'(RD_LATENCY - 2);

  mem_resp_state_t       r_state;
  mem_resp_state_t       w_state_nxt;
  logic [c_CNT_W-1:0]    r_cnt;
  logic                  w_cnt_load;
  logic [c_CNT_W-1:0]    w_cnt_load_val;

  logic [BLOCK_BITS-1:0] r_store [NUM_BLOCKS];
  logic [BLOCK_BITS-1:0] r_hold_data;
  logic [31:0]           r_hold_addr;

  logic                  w_req_accept;
  logic [31:0]           w_req_aligned;
  logic                  w_fifo_pop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [c_FIFO_CW-1:0]  w_fifo_count;
  logic [31:0]           w_head_addr;
  logic [c_INDEX_BITS-1:0] w_head_idx;
  logic [c_INDEX_BITS-1:0] w_wb_idx;
  logic                  w_fwd;
  logic [BLOCK_BITS-1:0] w_resp_data;
  logic                  w_resp_active;
  logic                  w_unused_wb_bits;

  // Only the block index of a writeback address selects storage; the byte
  // offset and the aliased upper bits carry no information here.
  assign w_unused_wb_bits = ^{mem_wb_addr_i[c_OFFSET_BITS-1:0],
                              mem_wb_addr_i[31:c_OFFSET_BITS+c_INDEX_BITS]};

  // ------------------------------------------------------------------------
  // Request queue. The request being serviced stays at the head until its
  // response cycle, so the queue depth bounds all outstanding refills.
  // ------------------------------------------------------------------------
  assign mem_req_rdy_o = !w_fifo_full;
  assign w_req_accept  = mem_req_vld_i && mem_req_rdy_o;
  assign w_req_aligned = block_align(mem_req_addr_i, c_OFFSET_BITS);
  assign w_fifo_pop    = (r_state == RESP);

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (REQ_FIFO_DEPTH)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_req_accept),
    .pop_i   (w_fifo_pop),
    .wdata_i (w_req_aligned),
    .rdata_o (w_head_addr),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count)
  );

  assign w_head_idx = w_head_addr[c_OFFSET_BITS +: c_INDEX_BITS];
  assign w_wb_idx   = mem_wb_addr_i[c_OFFSET_BITS +: c_INDEX_BITS];

  // ------------------------------------------------------------------------
  // Responder FSM
  // ------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and latency-counter load decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          if (RD_LATENCY == 2) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt    = WAIT;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = c_LOAD_FROM_IDLE;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) w_state_nxt = RESP;
      end
      RESP: begin
        // More than the responding entry queued: start the next one now.
        if (w_fifo_count > c_FIFO_CW'(1)) begin
          w_state_nxt    = WAIT;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = c_LOAD_FROM_RESP;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latency down-counter; holds at zero outside WAIT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_cnt_load) begin
      r_cnt <= w_cnt_load_val;
    end else if ((r_state == WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // ------------------------------------------------------------------------
  // Backing store and response path
  // ------------------------------------------------------------------------

  // Writebacks land on their accepting edge regardless of FSM or reset.
  always_ff @(posedge clk_i) begin
    if (mem_wb_vld_i) r_store[w_wb_idx] <= mem_wb_data_i;
  end

  // A writeback to the responding block in the RESP cycle is not yet in the
  // store, so it is forwarded straight to the response.
  assign w_fwd         = mem_wb_vld_i && (w_wb_idx == w_head_idx);
  assign w_resp_data   = w_fwd ? mem_wb_data_i : r_store[w_head_idx];
  assign w_resp_active = (r_state == RESP);

  // Keep the last response visible while no response is being driven.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hold_data <= '0;
      r_hold_addr <= '0;
    end else if (w_resp_active) begin
      r_hold_data <= w_resp_data;
      r_hold_addr <= w_head_addr;
    end
  end

  assign mem_resp_vld_o  = w_resp_active;
  assign mem_resp_data_o = w_resp_active ? w_resp_data : r_hold_data;
  assign mem_resp_addr_o = w_resp_active ? w_head_addr : r_hold_addr;
  assign busy_o          = !w_fifo_empty || (r_state != IDLE);

endmodule : main_memory_responder
`default_nettype wire

// File: tb/tb_main_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_memory_responder
// Description : Self-checking bench for main_memory_responder: directed
//               scenarios plus randomized traffic against a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main_memory_responder;
  import main_memory_responder_pkg::*;

  localparam int L     = 8;
  localparam int DEPTH = 4;
  localparam int NBLK  = 4096;

  typedef struct {
    logic [31:0] addr;
    int          t;
  } pend_t;

  logic        clk;
  logic        rst_i;
  logic        mem_req_vld_i;
  logic [31:0] mem_req_addr_i;
  logic        mem_req_rdy_o;
  logic        mem_resp_vld_o;
  mem_block_t  mem_resp_data_o;
  logic [31:0] mem_resp_addr_o;
  logic        mem_wb_vld_i;
  logic [31:0] mem_wb_addr_i;
  mem_block_t  mem_wb_data_i;
  logic        busy_o;

  main_memory_responder #(
    .BLOCK_BITS     (128),
    .NUM_BLOCKS     (NBLK),
    .RD_LATENCY     (L),
    .REQ_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .mem_req_vld_i   (mem_req_vld_i),
    .mem_req_addr_i  (mem_req_addr_i),
    .mem_req_rdy_o   (mem_req_rdy_o),
    .mem_resp_vld_o  (mem_resp_vld_o),
    .mem_resp_data_o (mem_resp_data_o),
    .mem_resp_addr_o (mem_resp_addr_o),
    .mem_wb_vld_i    (mem_wb_vld_i),
    .mem_wb_addr_i   (mem_wb_addr_i),
    .mem_wb_data_i   (mem_wb_data_i),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  // Reference model: memory image plus a queue of outstanding requests,
  // each tagged with the cycle in which its response is due.
  mem_block_t  model_mem [NBLK];
  pend_t       q [$];
  int          cyc;
  int          last_t;
  bit          model_ok;
  mem_block_t  last_data;
  logic [31:0] last_addr;

  int n_vec;
  int n_err;

  logic        s_vld;
  logic        s_rdy;
  logic        s_busy;
  mem_block_t  s_data;
  logic [31:0] s_addr;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_inputs();
    rst_i          = 1'b0;
    mem_req_vld_i  = 1'b0;
    mem_req_addr_i = '0;
    mem_wb_vld_i   = 1'b0;
    mem_wb_addr_i  = '0;
    mem_wb_data_i  = '0;
  endtask

  // One clock cycle: sample outputs mid-cycle, compare with the model,
  // then advance the model by the rules applied at the coming edge.
  task automatic tick();
    logic        exp_vld;
    logic        exp_rdy;
    logic        exp_busy;
    mem_block_t  exp_data;
    logic [31:0] exp_addr;
    int          hidx;
    int          widx;
    int          t;
    @(negedge clk);
    s_vld  = mem_resp_vld_o;
    s_rdy  = mem_req_rdy_o;
    s_busy = busy_o;
    s_data = mem_resp_data_o;
    s_addr = mem_resp_addr_o;

    widx     = int'(mem_wb_addr_i[15:4]);
    exp_vld  = (q.size() > 0) && (q[0].t == cyc);
    exp_rdy  = (q.size() < DEPTH);
    exp_busy = (q.size() > 0);
    exp_data = last_data;
    exp_addr = last_addr;
    if (exp_vld) begin
      exp_addr = q[0].addr;
      hidx     = int'(q[0].addr[15:4]);
      exp_data = (mem_wb_vld_i && widx == hidx) ? mem_wb_data_i : model_mem[hidx];
    end

    if (model_ok) begin
      check("resp_vld", s_vld, exp_vld);
      check("resp_data", s_data, exp_data);
      check("resp_addr", s_addr, exp_addr);
      check("req_rdy", s_rdy, exp_rdy);
      check("busy", s_busy, exp_busy);
    end

    if (rst_i) begin
      q.delete();
      last_t    = -1000;
      last_data = '0;
      last_addr = '0;
      model_ok  = 1'b1;
    end else begin
      if (exp_vld) begin
        void'(q.pop_front());
        last_data = exp_data;
        last_addr = exp_addr;
      end
      if (mem_req_vld_i && exp_rdy) begin
        t = (cyc > last_t) ? cyc + L : last_t + L;
        q.push_back('{addr: mem_req_addr_i & 32'hFFFF_FFF0, t: t});
        last_t = t;
      end
    end
    if (mem_wb_vld_i) model_mem[widx] = mem_wb_data_i;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom();
    if ($urandom_range(0, 3) != 0) a[15:4] = 12'(12'h040 + $urandom_range(0, 5));
    return a;
  endfunction

  // Protocol guard: the bench never offers a request the queue cannot take.
  always @(negedge clk) begin
    if (model_ok && !rst_i && mem_req_vld_i && !mem_req_rdy_o)
      $error("request presented while request queue is full");
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    clk       = 1'b0;
    cyc       = 0;
    last_t    = -1000;
    model_ok  = 1'b0;
    last_data = '0;
    last_addr = '0;
    n_vec     = 0;
    n_err     = 0;
    clear_inputs();

    // Power-up reset and reset-state checks.
    rst_i = 1'b1;
    repeat (3) tick();
    clear_inputs();
    check("rst_rdy", s_rdy, 1'b1);
    check("rst_busy", s_busy, 1'b0);
    check("rst_vld", s_vld, 1'b0);
    check("rst_data", s_data, 128'h0);
    check("rst_addr", s_addr, 32'h0);

    // Give every block a known, distinct value.
    for (int i = 0; i < NBLK; i++) begin
      mem_wb_vld_i  = 1'b1;
      mem_wb_addr_i = 32'(i) << 4;
      mem_wb_data_i = {32'(i), ~32'(i), 32'(i * 3), 32'hC0DE_0000 ^ 32'(i)};
      tick();
    end
    idle(2);

    // Writeback then refill of the same block with a non-zero offset.
    mem_wb_vld_i  = 1'b1;
    mem_wb_addr_i = 32'h0000_0040;
    mem_wb_data_i = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    tick();
    clear_inputs();
    mem_req_vld_i  = 1'b1;
    mem_req_addr_i = 32'h0000_0044;
    tick();
    clear_inputs();
    for (int k = 1; k <= L; k++) begin
      tick();
      check("t1_vld", s_vld, (k == L));
    end
    check("t1_data", s_data, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF);
    check("t1_addr", s_addr, 32'h0000_0040);
    idle(4);

    // Four back-to-back requests fill the queue; responses every L cycles.
    for (int k = 0; k < 4; k++) begin
      clear_inputs();
      mem_req_vld_i  = 1'b1;
      mem_req_addr_i = 32'(k * 16);
      tick();
    end
    clear_inputs();
    for (int k = 4; k <= 33; k++) begin
      tick();
      if (k == 4) check("t2_rdy_full", s_rdy, 1'b0);
      if (k == 8) check("t2_rdy_resp", s_rdy, 1'b0);
      if (k == 9) check("t2_rdy_back", s_rdy, 1'b1);
      if (k % 8 == 0) begin
        check("t2_vld", s_vld, 1'b1);
        check("t2_addr", s_addr, 32'((k / 8 - 1) * 16));
      end
    end
    idle(4);

    // Writeback in the response cycle is forwarded.
    mem_req_vld_i  = 1'b1;
    mem_req_addr_i = 32'h0000_0100;
    tick();
    clear_inputs();
    for (int k = 1; k <= L; k++) begin
      if (k == L) begin
        mem_wb_vld_i  = 1'b1;
        mem_wb_addr_i = 32'h0000_0100;
        mem_wb_data_i = {16{8'hA5}};
      end
      tick();
      clear_inputs();
    end
    check("t3_vld", s_vld, 1'b1);
    check("t3_fwd_data", s_data, {16{8'hA5}});
    idle(4);

    // Upper address bits alias onto the same block.
    mem_wb_vld_i  = 1'b1;
    mem_wb_addr_i = 32'h0001_0080;
    mem_wb_data_i = {16{8'h11}};
    tick();
    clear_inputs();
    mem_req_vld_i  = 1'b1;
    mem_req_addr_i = 32'h0000_0080;
    tick();
    idle(L);
    check("t4_alias_data", s_data, {16{8'h11}});
    check("t4_alias_addr", s_addr, 32'h0000_0080);
    idle(4);

    // Reset with one request in flight and two queued drops all of them.
    for (int k = 0; k < 3; k++) begin
      clear_inputs();
      mem_req_vld_i  = 1'b1;
      mem_req_addr_i = 32'(k * 16);
      tick();
    end
    idle(1);
    rst_i = 1'b1;
    tick();
    clear_inputs();
    tick();
    check("t5_busy", s_busy, 1'b0);
    check("t5_rdy", s_rdy, 1'b1);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (s_vld) seen++;
    end
    check("t5_no_resp", 32'(seen), 32'd0);
    mem_req_vld_i  = 1'b1;
    mem_req_addr_i = 32'h0000_0100;
    tick();
    idle(L);
    check("t5_store_kept", s_data, {16{8'hA5}});
    idle(4);

    // Request and writeback to the same block in the same cycle.
    mem_req_vld_i  = 1'b1;
    mem_req_addr_i = 32'h0000_0200;
    mem_wb_vld_i   = 1'b1;
    mem_wb_addr_i  = 32'h0000_0208;
    mem_wb_data_i  = {16{8'h77}};
    tick();
    idle(L);
    check("t6_vld", s_vld, 1'b1);
    check("t6_data", s_data, {16{8'h77}});
    idle(4);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      clear_inputs();
      if ($urandom_range(0, 299) == 0) begin
        rst_i = 1'b1;
      end else begin
        if ((q.size() < DEPTH) && ($urandom_range(0, 99) < 45)) begin
          mem_req_vld_i  = 1'b1;
          mem_req_addr_i = rand_addr();
        end
        if ($urandom_range(0, 99) < 35) begin
          mem_wb_vld_i  = 1'b1;
          mem_wb_addr_i = rand_addr();
          mem_wb_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
      end
      tick();
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_main_memory_responder
`default_nettype wire
